// File: rtl/yuv_pkg.sv
// rtl/yuv_pkg.sv - shared types, default widths and rounding-average helper for the 4:4:4 to 4:2:2 converter
package yuv_pkg;

   typedef enum logic {
      CSEL_U = 1'b0,
      CSEL_V = 1'b1
   } chroma_sel_t;

   localparam int DEF_DATA_W    = 8;
   localparam int DEF_PIX_CNT_W = 12;

   // Sum is exact for any component width below 32 bits, so the halved result never wraps.
   function automatic logic [31:0] avg_round(input logic [31:0] a, input logic [31:0] b);
      return (a + b + 32'd1) >> 1;
   endfunction

endpackage

// File: rtl/yuv444_to_422_if.sv
// rtl/yuv444_to_422_if.sv - pixel stream bundle: 4:4:4 input side and 4:2:2 output side
interface yuv444_to_422_if
   import yuv_pkg::*;
#(
   parameter int DATA_W = DEF_DATA_W
);
   logic              fv444;
   logic              lv444;
   logic [DATA_W-1:0] y444;
   logic [DATA_W-1:0] u444;
   logic [DATA_W-1:0] v444;

   logic              fv422;
   logic              lv422;
   logic [DATA_W-1:0] y422;
   logic [DATA_W-1:0] c422;
   chroma_sel_t       c_sel;

   modport master (
      output fv444, lv444, y444, u444, v444,
      input  fv422, lv422, y422, c422, c_sel
   );

   modport slave (
      input  fv444, lv444, y444, u444, v444,
      output fv422, lv422, y422, c422, c_sel
   );
endinterface

// File: rtl/yuv_line_tracker.sv
// rtl/yuv_line_tracker.sv - line edge detect, chroma phase, saturating pixel counter, line length/odd reporting
module yuv_line_tracker #(
   parameter int PIX_CNT_W = 12
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 lv,
   output logic                 phase,
   output logic [PIX_CNT_W-1:0] line_len,
   output logic                 line_odd
);
   logic                 lv_d;
   logic                 rise;
   logic                 fall;
   logic                 end_s1;
   logic [PIX_CNT_W-1:0] cnt;
   logic [PIX_CNT_W-1:0] len_s1;

   assign rise = lv & ~lv_d;
   assign fall = ~lv & lv_d;

   always_ff @(posedge clk) begin
      if (rst) begin
         lv_d     <= 1'b0;
         phase    <= 1'b0;
         cnt      <= '0;
         end_s1   <= 1'b0;
         len_s1   <= '0;
         line_len <= '0;
         line_odd <= 1'b0;
      end else begin
         lv_d  <= lv;
         phase <= lv ? ~phase : 1'b0;
         if (lv) begin
            if (rise)
               cnt <= PIX_CNT_W'(1);
            else if (!(&cnt))
               cnt <= cnt + PIX_CNT_W'(1);
         end
         // Extra stage keeps the line-end report aligned with the datapath's two-clock latency.
         end_s1   <= fall;
         len_s1   <= cnt;
         line_odd <= end_s1 & len_s1[0];
         if (end_s1)
            line_len <= len_s1;
      end
   end
endmodule

// File: rtl/yuv444_to_422.sv
// rtl/yuv444_to_422.sv - 4:4:4 to 4:2:2 chroma subsampler; define CHROMA_AVG_EN for averaged chroma
module yuv444_to_422
   import yuv_pkg::*;
#(
   parameter int DATA_W    = DEF_DATA_W,
   parameter int PIX_CNT_W = DEF_PIX_CNT_W
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   yuv444_to_422_if.slave       vid,
   output logic [PIX_CNT_W-1:0] line_len_o,
   output logic                 line_odd_o
);
   logic              lv;
   logic              phase;
   logic              s1_lv;
   logic              s1_fv;
   logic              s1_phase;
   logic [DATA_W-1:0] s1_y;
   logic [DATA_W-1:0] s1_u;
   logic [DATA_W-1:0] s1_v;
   logic [DATA_W-1:0] v_hold;
   logic [DATA_W-1:0] c_next;
   chroma_sel_t       sel_next;

   assign lv = vid.lv444 & vid.fv444;

   yuv_line_tracker #(
      .PIX_CNT_W(PIX_CNT_W)
   ) u_tracker (
      .clk      (clk_i),
      .rst      (rst_i),
      .lv       (lv),
      .phase    (phase),
      .line_len (line_len_o),
      .line_odd (line_odd_o)
   );

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         s1_lv     <= 1'b0;
         s1_fv     <= 1'b0;
         s1_phase  <= 1'b0;
         s1_y      <= '0;
         s1_u      <= '0;
         s1_v      <= '0;
         v_hold    <= '0;
         vid.fv422 <= 1'b0;
         vid.lv422 <= 1'b0;
         vid.y422  <= '0;
         vid.c422  <= '0;
         vid.c_sel <= CSEL_U;
      end else begin
         s1_lv    <= lv;
         s1_fv    <= vid.fv444;
         s1_phase <= phase;
         s1_y     <= vid.y444;
         s1_u     <= vid.u444;
         s1_v     <= vid.v444;
         // Even pixel's Cr waits here for its odd partner; deliberately not cleared between lines.
         if (s1_lv && !s1_phase)
            v_hold <= s1_v;
         vid.fv422 <= s1_fv;
         vid.lv422 <= s1_lv;
         vid.y422  <= s1_lv ? s1_y : '0;
         vid.c422  <= c_next;
         vid.c_sel <= sel_next;
      end
   end

   always_comb begin
      c_next   = '0;
      sel_next = CSEL_U;
      if (s1_lv) begin
         if (s1_phase) begin
            sel_next = CSEL_V;
`ifdef CHROMA_AVG_EN
            c_next = DATA_W'(avg_round(32'(v_hold), 32'(s1_v)));
`else
            c_next = v_hold;
`endif
         end else begin
`ifdef CHROMA_AVG_EN
            // The live input is this pixel's odd partner; an unpaired last pixel keeps its own Cb.
            c_next = lv ? DATA_W'(avg_round(32'(s1_u), 32'(vid.u444))) : s1_u;
`else
            c_next = s1_u;
`endif
         end
      end
   end
endmodule

// File: tb/tb_yuv444_to_422.sv
// tb/tb_yuv444_to_422.sv - scoreboard bench for yuv444_to_422 (both CHROMA_AVG_EN builds)
module tb_yuv444_to_422;

`ifdef CHROMA_AVG_EN
   localparam bit AVG = 1'b1;
`else
   localparam bit AVG = 1'b0;
`endif

   typedef struct packed {
      logic [7:0] y;
      logic [7:0] c;
      logic       sel;
   } pix_t;

   typedef struct packed {
      logic [11:0] len;
      logic        odd;
   } end_t;

   bit          clk = 1'b0;
   logic        rst = 1'b1;
   logic [11:0] line_len;
   logic        line_odd;

   pix_t exp_q[$];
   end_t end_q[$];

   int checks = 0;
   int errors = 0;

   logic rd1 = 1'b0, rd2 = 1'b0;
   logic fm1 = 1'b0, fm2 = 1'b0;
   logic lvo_prev = 1'b0;

   yuv444_to_422_if #(.DATA_W(8)) vid ();

   yuv444_to_422 #(
      .DATA_W    (8),
      .PIX_CNT_W (12)
   ) dut (
      .clk_i      (clk),
      .rst_i      (rst),
      .vid        (vid),
      .line_len_o (line_len),
      .line_odd_o (line_odd)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input int got, input int expv);
      checks++;
      if (got !== expv) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, got, expv, $time);
      end
   endtask

   // Reference delay line for FrameValid and reset window tracking.
   always @(posedge clk) begin
      rd1 <= rst;
      rd2 <= rd1;
      fm1 <= rst ? 1'b0 : vid.fv444;
      fm2 <= rst ? 1'b0 : fm1;
   end

   always @(negedge clk) begin
      pix_t p;
      end_t e;
      if (rd1 || rd2) begin
         chk("rst_fv_o", vid.fv422, 0);
         chk("rst_lv_o", vid.lv422, 0);
         chk("rst_y_o", vid.y422, 0);
         chk("rst_c_o", vid.c422, 0);
         chk("rst_csel_o", vid.c_sel, 0);
         chk("rst_line_odd", line_odd, 0);
      end else begin
         chk("fv_o_delay", vid.fv422, fm2);
         if (vid.lv422) begin
            if (exp_q.size() == 0) begin
               chk("pix_unexpected", 1, 0);
            end else begin
               p = exp_q.pop_front();
               chk("pix_y", vid.y422, p.y);
               chk("pix_c", vid.c422, p.c);
               chk("pix_csel", vid.c_sel, p.sel);
            end
         end else begin
            chk("idle_y", vid.y422, 0);
            chk("idle_c", vid.c422, 0);
            chk("idle_csel", vid.c_sel, 0);
         end
         if (lvo_prev && !vid.lv422) begin
            if (end_q.size() == 0) begin
               chk("line_end_unexpected", 1, 0);
            end else begin
               e = end_q.pop_front();
               chk("line_len", line_len, e.len);
               chk("line_odd", line_odd, e.odd);
            end
         end else begin
            chk("line_odd_idle", line_odd, 0);
         end
      end
      lvo_prev = vid.lv422;
   end

   task automatic drive(input logic fv, input logic lv, input logic [7:0] y, input logic [7:0] u,
                        input logic [7:0] v);
      vid.fv444 = fv;
      vid.lv444 = lv;
      vid.y444  = y;
      vid.u444  = u;
      vid.v444  = v;
      @(posedge clk);
      #1;
   endtask

   task automatic pix(input logic [7:0] y, input logic [7:0] u, input logic [7:0] v,
                      input logic [7:0] c, input logic sel);
      exp_q.push_back({y, c, sel});
      drive(1'b1, 1'b1, y, u, v);
   endtask

   task automatic line_end(input logic [11:0] len);
      end_q.push_back({len, len[0]});
   endtask

   task automatic idle(input int n, input logic fv);
      for (int i = 0; i < n; i++)
         drive(fv, 1'b0, 8'd0, 8'd0, 8'd0);
   endtask

   initial begin
      rst = 1'b1;
      idle(4, 1'b0);
      rst = 1'b0;
      idle(2, 1'b1);
      chk("reset_line_len", line_len, 0);

      // 4-pixel line
      pix(8'd10, 8'd20, 8'd30, AVG ? 8'd21 : 8'd20, 1'b0);
      pix(8'd11, 8'd21, 8'd31, AVG ? 8'd31 : 8'd30, 1'b1);
      pix(8'd12, 8'd22, 8'd32, AVG ? 8'd23 : 8'd22, 1'b0);
      pix(8'd13, 8'd23, 8'd33, AVG ? 8'd33 : 8'd32, 1'b1);
      line_end(12'd4);
      idle(3, 1'b1);

      // reset mid-line, lv held high through release
      pix(8'd100, 8'd110, 8'd120, AVG ? 8'd111 : 8'd110, 1'b0);
      drive(1'b1, 1'b1, 8'd101, 8'd111, 8'd121);
      rst = 1'b1;
      for (int i = 0; i < 3; i++)
         drive(1'b1, 1'b1, 8'(102 + i), 8'(112 + i), 8'(122 + i));
      rst = 1'b0;
      pix(8'd105, 8'd115, 8'd125, AVG ? 8'd116 : 8'd115, 1'b0);
      chk("line_len_after_reset", line_len, 0);
      pix(8'd106, 8'd116, 8'd126, AVG ? 8'd126 : 8'd125, 1'b1);
      line_end(12'd2);
      idle(3, 1'b1);

      // 5-pixel odd line
      pix(8'd40, 8'd50, 8'd60, AVG ? 8'd51 : 8'd50, 1'b0);
      pix(8'd41, 8'd51, 8'd61, AVG ? 8'd61 : 8'd60, 1'b1);
      pix(8'd42, 8'd52, 8'd62, AVG ? 8'd53 : 8'd52, 1'b0);
      pix(8'd43, 8'd53, 8'd63, AVG ? 8'd63 : 8'd62, 1'b1);
      pix(8'd44, 8'd54, 8'd64, 8'd54, 1'b0);
      line_end(12'd5);
      idle(2, 1'b1);

      // 3 high, 1-cycle gap, 2 high
      pix(8'd70, 8'd80, 8'd90, AVG ? 8'd81 : 8'd80, 1'b0);
      pix(8'd71, 8'd81, 8'd91, AVG ? 8'd91 : 8'd90, 1'b1);
      pix(8'd72, 8'd82, 8'd92, 8'd82, 1'b0);
      line_end(12'd3);
      idle(1, 1'b1);
      pix(8'd73, 8'd83, 8'd93, AVG ? 8'd84 : 8'd83, 1'b0);
      pix(8'd74, 8'd84, 8'd94, AVG ? 8'd94 : 8'd93, 1'b1);
      line_end(12'd2);
      idle(3, 1'b1);

      // chroma extremes, no wrap in the average
      pix(8'd1, 8'd255, 8'd0, 8'd255, 1'b0);
      pix(8'd2, 8'd254, 8'd255, AVG ? 8'd128 : 8'd0, 1'b1);
      line_end(12'd2);
      idle(3, 1'b1);

      // FrameValid low masks LineValid; FrameValid falling mid-line ends the line
      for (int i = 0; i < 3; i++)
         drive(1'b0, 1'b1, 8'd50, 8'd60, 8'd70);
      idle(2, 1'b1);
      pix(8'd5, 8'd8, 8'd11, AVG ? 8'd9 : 8'd8, 1'b0);
      pix(8'd6, 8'd9, 8'd12, AVG ? 8'd12 : 8'd11, 1'b1);
      pix(8'd7, 8'd10, 8'd13, 8'd10, 1'b0);
      line_end(12'd3);
      drive(1'b0, 1'b1, 8'd9, 8'd9, 8'd9);
      drive(1'b0, 1'b1, 8'd9, 8'd9, 8'd9);
      idle(5, 1'b0);

      chk("pix_queue_drained", exp_q.size(), 0);
      chk("end_queue_drained", end_q.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
